// File: rtl/multi_bot_scoreboard.sv
// multi_bot_scoreboard: debounced finish-line detector and BCD scorer for NUM_BOTS bots.
// Optional round timeout is enabled by defining ROUND_TIMEOUT_EN.
module multi_bot_scoreboard #(
  parameter int          NUM_BOTS       = 2,
  parameter int          DIGITS         = 2,
  parameter logic [7:0]  LINE_MASK      = 8'h07,
  parameter int          DEBOUNCE       = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  localparam int         IDW            = (NUM_BOTS > 1) ? $clog2(NUM_BOTS) : 1,
  localparam int         SW             = 4*DIGITS
)(
  input  logic                   clk,
  input  logic                   board_rst_n,
  input  logic [8*NUM_BOTS-1:0]  sensors,
  input  logic                   map_rst,
  output logic [SW*NUM_BOTS-1:0] score,
  output logic                   map_change,
  output logic [IDW-1:0]         winner_id,
  output logic                   winner_valid,
  output logic [NUM_BOTS-1:0]    crossed
);
  typedef enum logic [1:0] {IDLE, ON_LINE, SCORED} state_t;
  logic [7:0]          r_s1 [NUM_BOTS];
  logic [7:0]          r_s2 [NUM_BOTS];
  logic [7:0]          r_cnt [NUM_BOTS];
  logic [SW-1:0]       r_score [NUM_BOTS];
  state_t              r_state [NUM_BOTS];
  state_t              w_state_nxt [NUM_BOTS];
  logic [NUM_BOTS-1:0] r_deb_on, r_cross, w_raw_on, w_cross_nxt, w_cross;
  logic                r_map_change, r_winner_valid, w_any, w_tick;
  logic [IDW-1:0]      r_winner_id, w_first;
  // Increment a BCD number with ripple carry; all-nines saturates.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++)
      if (c) begin
        c = (v[4*d +: 4] == 4'd9);
        r[4*d +: 4] = c ? 4'd0 : v[4*d +: 4] + 4'd1;
      end
    return c ? v : r;
  endfunction
  always_ff @(posedge clk or negedge board_rst_n)
    if (!board_rst_n) begin
      for (int i = 0; i < NUM_BOTS; i++) begin
        r_s1[i]  <= '0;
        r_s2[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_deb_on <= '0;
    end else
      for (int i = 0; i < NUM_BOTS; i++) begin
        r_s1[i] <= sensors[8*i +: 8];
        r_s2[i] <= r_s1[i];
        if (w_raw_on[i] == r_deb_on[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == 8'(DEBOUNCE-1)) begin
          r_cnt[i]    <= '0;
          r_deb_on[i] <= w_raw_on[i];
        end else r_cnt[i] <= r_cnt[i] + 8'd1;
      end
  always_comb begin
    w_first = '0;
    for (int i = 0; i < NUM_BOTS; i++) begin
      w_raw_on[i]    = ~|(r_s2[i] & LINE_MASK);
      w_state_nxt[i] = r_state[i];
      w_cross_nxt[i] = 1'b0;
      if (map_rst) w_state_nxt[i] = IDLE;
      else if (r_state[i] == IDLE && r_deb_on[i]) w_state_nxt[i] = ON_LINE;
      else if (r_state[i] == ON_LINE && !r_deb_on[i]) begin
        w_state_nxt[i] = SCORED;
        w_cross_nxt[i] = 1'b1;
      end
    end
    w_cross = map_rst ? '0 : r_cross;
    w_any   = |w_cross;
    for (int i = NUM_BOTS-1; i >= 0; i--)
      if (w_cross[i]) w_first = IDW'(i);
  end
  always_ff @(posedge clk or negedge board_rst_n)
    if (!board_rst_n) begin
      for (int i = 0; i < NUM_BOTS; i++) begin
        r_state[i] <= IDLE;
        r_score[i] <= '0;
      end
      r_cross        <= '0;
      r_map_change   <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cross <= w_cross_nxt;
      for (int i = 0; i < NUM_BOTS; i++)
        if (w_cross[i]) r_score[i] <= bcd_inc(r_score[i]);
      r_map_change <= (w_any && !r_winner_valid) || w_tick;
      if (map_rst) begin
        r_winner_valid <= 1'b0;
        r_winner_id    <= '0;
      end else if (w_any && !r_winner_valid) begin
        r_winner_valid <= 1'b1;
        r_winner_id    <= w_first;
      end
    end
`ifdef ROUND_TIMEOUT_EN
  logic [31:0] r_timer;
  assign w_tick = !map_rst && !r_winner_valid && (r_timer == TIMEOUT_CYCLES - 32'd1);
  always_ff @(posedge clk or negedge board_rst_n)
    if (!board_rst_n) r_timer <= '0;
    else if (map_rst || w_any || w_tick) r_timer <= '0;
    else if (!r_winner_valid) r_timer <= r_timer + 32'd1;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_tick = 1'b0;
`endif
  for (genvar g = 0; g < NUM_BOTS; g++) begin : g_out
    assign score[SW*(NUM_BOTS-g)-1 -: SW] = r_score[g];
    assign crossed[g] = (r_state[g] == SCORED);
  end
  assign map_change   = r_map_change;
  assign winner_valid = r_winner_valid;
  assign winner_id    = r_winner_id;
endmodule

// File: tb/tb_multi_bot_scoreboard.sv
// tb_multi_bot_scoreboard: table-driven vectors plus hand sequences for latency,
// map_rst/crossing collision, saturation, async reset and optional round timeout.
module tb_multi_bot_scoreboard;
  logic        clk = 1'b0;
  logic        board_rst_n, map_rst;
  logic [15:0] sensors;
  logic [15:0] score;
  logic        map_change, winner_valid;
  logic [0:0]  winner_id;
  logic [1:0]  crossed;
  int          n_pulse = 0;
  int          n_vec = 0;
  int          n_err = 0;

  multi_bot_scoreboard #(
    .NUM_BOTS(2), .DIGITS(2), .LINE_MASK(8'h07), .DEBOUNCE(4), .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk(clk), .board_rst_n(board_rst_n), .sensors(sensors), .map_rst(map_rst),
    .score(score), .map_change(map_change), .winner_id(winner_id),
    .winner_valid(winner_valid), .crossed(crossed)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (map_change) n_pulse++;

  typedef struct {
    logic        mrst;
    logic [7:0]  s0, s1;
    int          cyc;
    logic [15:0] score;
    logic [1:0]  crossed;
    logic        wv;
    logic        wid;
    int          pulses;
  } vec_t;
  vec_t vt [15];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic new_round(input logic [7:0] s0, input logic [7:0] s1);
    sensors = {s1, s0};
    map_rst = 1'b1;
    tick(1);
    map_rst = 1'b0;
    tick(10);
  endtask

  initial begin
    int p0, first, e0, e1, k1, k2;
    vt[0]  = '{1'b0, 8'h07, 8'h07, 5,  16'h0000, 2'b00, 1'b0, 1'b0, 0};
    vt[1]  = '{1'b0, 8'h00, 8'h07, 10, 16'h0000, 2'b00, 1'b0, 1'b0, 0};
    vt[2]  = '{1'b0, 8'h07, 8'h07, 12, 16'h0100, 2'b01, 1'b1, 1'b0, 1};
    vt[3]  = '{1'b0, 8'h07, 8'h00, 3,  16'h0100, 2'b01, 1'b1, 1'b0, 0};
    vt[4]  = '{1'b0, 8'h07, 8'h07, 12, 16'h0100, 2'b01, 1'b1, 1'b0, 0};
    vt[5]  = '{1'b1, 8'h07, 8'h07, 5,  16'h0100, 2'b00, 1'b0, 1'b0, 0};
    vt[6]  = '{1'b0, 8'h00, 8'h00, 10, 16'h0100, 2'b00, 1'b0, 1'b0, 0};
    vt[7]  = '{1'b0, 8'h07, 8'h07, 12, 16'h0201, 2'b11, 1'b1, 1'b0, 1};
    vt[8]  = '{1'b0, 8'h00, 8'h07, 10, 16'h0201, 2'b11, 1'b1, 1'b0, 0};
    vt[9]  = '{1'b0, 8'h07, 8'h07, 12, 16'h0201, 2'b11, 1'b1, 1'b0, 0};
    vt[10] = '{1'b1, 8'h07, 8'h00, 10, 16'h0201, 2'b00, 1'b0, 1'b0, 0};
    vt[11] = '{1'b0, 8'h07, 8'h07, 12, 16'h0202, 2'b10, 1'b1, 1'b1, 1};
    vt[12] = '{1'b0, 8'h00, 8'h07, 10, 16'h0202, 2'b10, 1'b1, 1'b1, 0};
    vt[13] = '{1'b1, 8'h00, 8'h07, 10, 16'h0202, 2'b00, 1'b0, 1'b0, 0};
    vt[14] = '{1'b0, 8'h07, 8'h07, 12, 16'h0302, 2'b01, 1'b1, 1'b0, 1};
    board_rst_n = 1'b0;
    map_rst     = 1'b0;
    sensors     = 16'h0707;
    tick(3);
    board_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      sensors = {vt[i].s1, vt[i].s0};
      if (vt[i].mrst) begin
        map_rst = 1'b1;
        tick(1);
        map_rst = 1'b0;
      end
      p0 = n_pulse;
      tick(vt[i].cyc);
      check($sformatf("v%0d.score", i), score, vt[i].score);
      check($sformatf("v%0d.crossed", i), crossed, vt[i].crossed);
      check($sformatf("v%0d.winner_valid", i), winner_valid, vt[i].wv);
      check($sformatf("v%0d.winner_id", i), winner_id, vt[i].wid);
      check($sformatf("v%0d.pulses", i), n_pulse - p0, vt[i].pulses);
    end
    // exact latency: pulse and score update 8 cycles after sensor change
    new_round(8'h00, 8'h07);
    sensors = 16'h0707;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (map_change && first == 0) first = k;
    end
    check("latency.pulse_cycle", first, 8);
    check("latency.score", score, 16'h0402);
    // map_rst in the same cycle as cross: no score, no pulse
    new_round(8'h00, 8'h07);
    sensors = 16'h0707;
    p0 = n_pulse;
    tick(7);
    map_rst = 1'b1;
    tick(1);
    map_rst = 1'b0;
    tick(5);
    check("collide.score", score, 16'h0402);
    check("collide.pulses", n_pulse - p0, 0);
    check("collide.crossed", crossed, 2'b00);
    check("collide.winner_valid", winner_valid, 1'b0);
    // saturation: drive bot0 to 99 and bot1 to 09
    e0 = 4;
    e1 = 2;
    p0 = n_pulse;
    for (int r = 0; r < 95; r++) begin
      new_round(8'h00, (r < 7) ? 8'h00 : 8'h07);
      sensors = 16'h0707;
      tick(12);
      e0++;
      if (r < 7) e1++;
    end
    check("sat.pre_score", score, {bcd(e0), bcd(e1)});
    check("sat.pre_pulses", n_pulse - p0, 95);
    new_round(8'h00, 8'h00);
    sensors = 16'h0707;
    tick(8);
    e0 = (e0 < 99) ? e0 + 1 : 99;
    e1++;
    check("sat.score", score, {bcd(e0), bcd(e1)});
    check("sat.map_change", map_change, 1'b1);
    check("sat.winner_id", winner_id, 1'b0);
    check("sat.crossed", crossed, 2'b11);
    // async reset in mid-cycle, while map_change is high
    #3 board_rst_n = 1'b0;
    #1;
    check("areset.score", score, 16'h0000);
    check("areset.map_change", map_change, 1'b0);
    check("areset.crossed", crossed, 2'b00);
    check("areset.winner_valid", winner_valid, 1'b0);
    #2 board_rst_n = 1'b1;
    tick(2);
    // round timeout (only pulses when the feature is built in)
    map_rst = 1'b1;
    tick(1);
    map_rst = 1'b0;
    k1 = 0;
    k2 = 0;
    p0 = n_pulse;
    for (int k = 1; k <= 250; k++) begin
      tick(1);
      if (map_change) begin
        if (k1 == 0) k1 = k;
        else if (k2 == 0) k2 = k;
      end
    end
`ifdef ROUND_TIMEOUT_EN
    check("timeout.first", k1, 100);
    check("timeout.second", k2, 200);
    check("timeout.pulses", n_pulse - p0, 2);
`else
    check("timeout.pulses", n_pulse - p0, 0);
`endif
    check("timeout.score", score, 16'h0000);
    check("timeout.winner_valid", winner_valid, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
